// File: rtl/alu_seq_ctrl_if.sv
// EX-stage request/result bundle between the pipeline and the ALU sequencing controller.
interface alu_seq_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] c;
    logic             zero;
    logic             div_by_zero;

    modport master (
        output start, flush, op, a, b,
        input  busy, stall, done, c, zero, div_by_zero
    );

    modport slave (
        input  start, flush, op, a, b,
        output busy, stall, done, c, zero, div_by_zero
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// EX-stage ALU sequencer: single-cycle logic/add ops, iterative shift-add mul and restoring div/mod.
// Define ALU_MUL_EARLY_TERM_EN to end a multiply once the remaining multiplier bits are all zero.
module alu_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_seq_ctrl_if.slave alu_io
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // mul partial product / div partial remainder
    logic [WIDTH-1:0] x_q, x_d;       // mul multiplicand / div dividend shifting into quotient
    logic [WIDTH-1:0] y_q, y_d;       // mul multiplier / div divisor
    logic [WIDTH-1:0] c_q, c_d;
    logic             is_mod_q, is_mod_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             b_zero, is_long, can_accept, short_dbz;
    logic [WIDTH-1:0] short_res;
    logic [WIDTH-1:0] mul_acc, mul_y;
    logic [WIDTH:0]   div_sh, div_sub;
    logic [WIDTH-1:0] div_rem, div_quo;
    logic             div_ge;

    always_comb begin
        b_zero    = (alu_io.b == '0);
        short_dbz = 1'b0;
        case (alu_io.op)
            4'd0:    short_res = alu_io.a + alu_io.b;
            4'd1:    short_res = alu_io.a - alu_io.b;
            4'd3:    begin short_res = '1;       short_dbz = 1'b1; end
            4'd4:    short_res = alu_io.a & alu_io.b;
            4'd5:    short_res = alu_io.a | alu_io.b;
            4'd6:    short_res = alu_io.a ^ alu_io.b;
            4'd7:    begin short_res = alu_io.a; short_dbz = 1'b1; end
            default: short_res = '0;
        endcase
`ifdef ALU_MUL_EARLY_TERM_EN
        is_long = ((alu_io.op == 4'd2) || (alu_io.op == 4'd3) || (alu_io.op == 4'd7)) && !b_zero;
`else
        is_long = (alu_io.op == 4'd2) || (((alu_io.op == 4'd3) || (alu_io.op == 4'd7)) && !b_zero);
`endif
    end

    always_comb begin
        mul_acc = acc_q + (y_q[0] ? x_q : '0);
        mul_y   = y_q >> 1;
        div_sh  = {acc_q, x_q[WIDTH-1]};
        div_sub = div_sh - {1'b0, y_q};
        div_ge  = ~div_sub[WIDTH];
        div_rem = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_quo = {x_q[WIDTH-2:0], div_ge};
    end

    assign can_accept = (state_q == StIdle) || (state_q == StDone);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        c_d      = c_q;
        is_mod_d = is_mod_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        if (alu_io.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (alu_io.start) begin
                        dbz_d = 1'b0;
                        if (is_long) begin
                            acc_d    = '0;
                            x_d      = alu_io.a;
                            y_d      = alu_io.b;
                            cnt_d    = CntInit;
                            is_mod_d = (alu_io.op == 4'd7);
                            state_d  = (alu_io.op == 4'd2) ? StMul : StDiv;
                        end else begin
                            c_d    = short_res;
                            dbz_d  = short_dbz;
                            done_d = 1'b1;
                        end
                    end
                end
                StMul: begin
                    acc_d = mul_acc;
                    x_d   = x_q << 1;
                    y_d   = mul_y;
                    cnt_d = cnt_q - CntW'(1);
`ifdef ALU_MUL_EARLY_TERM_EN
                    if ((cnt_q == CntW'(1)) || (mul_y == '0)) begin
`else
                    if (cnt_q == CntW'(1)) begin
`endif
                        state_d = StDone;
                        c_d     = mul_acc;
                        done_d  = 1'b1;
                    end
                end
                StDiv: begin
                    acc_d = div_rem;
                    x_d   = div_quo;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StDone;
                        c_d     = is_mod_q ? div_rem : div_quo;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            c_q      <= '0;
            is_mod_q <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            c_q      <= c_d;
            is_mod_q <= is_mod_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    // A long op accepted in the done cycle must hold the pipeline as well, or the
    // next instruction would enter EX while this one still occupies the unit.
    assign alu_io.busy        = (state_q != StIdle);
    assign alu_io.stall       = (alu_io.busy && (state_q != StDone)) ||
                                (alu_io.start && !alu_io.flush && is_long && can_accept);
    assign alu_io.done        = done_q;
    assign alu_io.c           = c_q;
    assign alu_io.zero        = (c_q == '0);
    assign alu_io.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed scoreboard bench for alu_seq_ctrl (WIDTH=32); honours ALU_MUL_EARLY_TERM_EN if defined.
module tb_alu_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [32:0] sb[$];         // {div_by_zero, c}
    logic [31:0] last_c = '0;

    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.WIDTH(32)) alu_if ();

    alu_seq_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_io (alu_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            4'd0:    return {1'b0, a + b};
            4'd1:    return {1'b0, a - b};
            4'd2:    return {1'b0, p[31:0]};
            4'd3:    return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
            4'd4:    return {1'b0, a & b};
            4'd5:    return {1'b0, a | b};
            4'd6:    return {1'b0, a ^ b};
            4'd7:    return (b == 0) ? {1'b1, a} : {1'b0, a % b};
            default: return 33'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
        int msb;
        if ((op == 4'd3 || op == 4'd7) && b != 0) return 33;
        if (op != 4'd2) return 1;
`ifdef ALU_MUL_EARLY_TERM_EN
        if (b == 0) return 1;
        msb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        return msb + 2;
`else
        msb = 0;
        return 33 + msb;
`endif
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && alu_if.done === 1'b1) begin
            logic [32:0] e;
            chk("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result_c", alu_if.c, e[31:0]);
                chk("result_zero", 32'(alu_if.zero), 32'(e[31:0] == 0));
                chk("result_dbz", 32'(alu_if.div_by_zero), 32'(e[32]));
            end
        end
    end

    // Drives one request; returns at the negedge of the done cycle.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit from_idle, input string tag);
        logic [32:0] m;
        int el, lat;
        bit long_op, bad;
        m = model(op, a, b);
        el = exp_lat(op, b);
        long_op = (el > 1);
        alu_if.op = op;
        alu_if.a = a;
        alu_if.b = b;
        alu_if.start = 1'b1;
        sb.push_back(m);
        last_c = m[31:0];
        #1;
        if (from_idle) chk({tag, "_req_stall"}, 32'(alu_if.stall), 32'(long_op));
        @(posedge clk);
        #1;
        alu_if.start = 1'b0;
        lat = 0;
        bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (alu_if.done === 1'b1) begin
                lat = k;
                break;
            end
            if (alu_if.stall !== long_op || alu_if.busy !== long_op) bad = 1'b1;
            @(posedge clk);
        end
        chk({tag, "_latency"}, 32'(lat), 32'(el));
        chk({tag, "_stall_busy_run"}, 32'(bad), 32'd0);
        chk({tag, "_done_stall"}, 32'(alu_if.stall), 32'd0);
        chk({tag, "_done_busy"}, 32'(alu_if.busy), 32'(long_op));
    endtask

    task automatic gap();
        @(posedge clk);
        #1;
    endtask

    initial begin
        alu_if.start = 1'b0;
        alu_if.flush = 1'b0;
        alu_if.op = '0;
        alu_if.a = '0;
        alu_if.b = '0;
        #1;
        chk("rst_busy", 32'(alu_if.busy), 32'd0);
        chk("rst_done", 32'(alu_if.done), 32'd0);
        chk("rst_c", alu_if.c, 32'd0);
        chk("rst_zero", 32'(alu_if.zero), 32'd1);
        chk("rst_dbz", 32'(alu_if.div_by_zero), 32'd0);
        chk("rst_stall", 32'(alu_if.stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gap();

        do_op(4'd0, 32'd5, 32'd7, 1'b1, "add");                         gap();
        do_op(4'd1, 32'd3, 32'd5, 1'b1, "sub_wrap");                    gap();
        do_op(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, "and");         gap();
        do_op(4'd5, 32'hF000_0001, 32'h0000_0F10, 1'b1, "or");          gap();
        do_op(4'd6, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1, "xor");         gap();
        do_op(4'd9, 32'd11, 32'd13, 1'b1, "illegal");                   gap();
        do_op(4'd2, 32'd3, 32'h10, 1'b1, "mul");                        gap();
        do_op(4'd2, 32'hFFFF_FFFF, 32'd3, 1'b1, "mul_wrap");            gap();
        do_op(4'd2, 32'd77, 32'd0, 1'b1, "mul_b0");                     gap();
        do_op(4'd3, 32'd100, 32'd7, 1'b1, "div");
        do_op(4'd7, 32'd100, 32'd7, 1'b0, "mod_b2b");                   gap();
        do_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "div_big");     gap();
        do_op(4'd7, 32'd5, 32'h8000_0000, 1'b1, "mod_big");             gap();
        do_op(4'd3, 32'd9, 32'd0, 1'b1, "div_b0");                      gap();
        do_op(4'd7, 32'd9, 32'd0, 1'b1, "mod_b0");                      gap();
        do_op(4'd0, 32'd2, 32'd3, 1'b1, "add_clr_dbz");                 gap();

        // Flush a multiply in flight; starts while busy are ignored.
        alu_if.op = 4'd2;
        alu_if.a = 32'd3;
        alu_if.b = 32'h8000_0000;
        alu_if.start = 1'b1;
        gap();
        for (int k = 2; k <= 9; k++) begin
            alu_if.op = 4'd0;
            alu_if.a = 32'd1;
            alu_if.b = 32'd1;
            alu_if.start = 1'b1;
            chk("flush_busy_hold", 32'(alu_if.busy), 32'd1);
            gap();
        end
        alu_if.start = 1'b0;
        alu_if.flush = 1'b1;
        gap();
        alu_if.flush = 1'b0;
        chk("flush_busy", 32'(alu_if.busy), 32'd0);
        chk("flush_stall", 32'(alu_if.stall), 32'd0);
        chk("flush_c_kept", alu_if.c, last_c);
        begin
            bit saw_done;
            saw_done = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (alu_if.done === 1'b1) saw_done = 1'b1;
            end
            chk("flush_no_done", 32'(saw_done), 32'd0);
        end
        gap();

        // Asynchronous reset in the middle of a division.
        alu_if.op = 4'd3;
        alu_if.a = 32'd1000;
        alu_if.b = 32'd3;
        alu_if.start = 1'b1;
        gap();
        alu_if.start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(alu_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(alu_if.busy), 32'd0);
        chk("async_rst_c", alu_if.c, 32'd0);
        chk("async_rst_zero", 32'(alu_if.zero), 32'd1);
        chk("async_rst_stall", 32'(alu_if.stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) gap();
        chk("post_rst_c", alu_if.c, 32'd0);
        do_op(4'd1, 32'd5, 32'd5, 1'b1, "sub_zero");                    gap();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule
